// File: rtl/uart_pkg.sv
// Shared UART definitions: frame data width, transmitter FSM states and the
// baud divider helper. The PARITY state exists only when UART_TX_PARITY_EN
// is defined.
package uart_pkg;

  // Data bits per frame, also used by the receiver.
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  // Clock cycles per bit, truncated.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte stream into the UART transmitter.
//
// Handshake: a byte transfers on a rising clock edge where valid_in and
// ready_out are both high. The master holds data_in stable while valid_in is
// high and not yet accepted; ready_out never depends on valid_in.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_in;
  logic                 valid_in;
  logic                 ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO buffering bytes ahead of the serialiser. Read data is
// first-word-fall-through: rdata shows the head entry whenever !empty.
// Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two; level tracks
  // occupancy and is unchanged on a simultaneous push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter. Bytes from the stream interface queue in a
// FIFO; the FSM pops one per frame and shifts it out LSB first on RsTx,
// timed by an internal baud divider. A waiting byte is popped on the edge
// that ends the last stop bit, so back-to-back frames have no idle gap.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after
// data bit 7.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  uart_tx_if.slave                      tx_in,
  output logic                          RsTx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output tx_state_t                     state_dbg
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  logic                 fifo_push;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 baud_last;
  logic                 load_frame;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign tx_in.ready_out = !fifo_full;
  assign fifo_push       = tx_in.valid_in && !fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (tx_in.data_in),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign baud_last = (cnt_q == CW'(DIV - 1));

  // Next-state, baud/bit counters, frame loading and the next line level.
  always_comb begin
    state_d    = state_q;
    cnt_d      = baud_last ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    load_frame = 1'b0;
    fifo_pop   = 1'b0;
    tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) load_frame = 1'b1;
      end
      TX_START: begin
        if (baud_last) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (baud_last) state_d = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (baud_last) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!fifo_empty) load_frame = 1'b1;
            else             state_d    = TX_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Pop the head byte and begin a new frame with its start bit.
    if (load_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      bit_d    = '0;
      cnt_d    = '0;
      state_d  = TX_START;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_rdata;
`endif
    end

    unique case (state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // FSM and datapath registers; the line is registered so it has no
  // combinational path from any input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign RsTx      = tx_q;
  assign busy      = (state_q != TX_IDLE) | (fifo_level != '0);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=10 (1 MHz clock, 100 kbaud). A line
// monitor decodes every frame and compares it against an expected byte queue.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD      = 100_000;
  localparam int DIV       = 10;
  localparam int DEPTH     = 16;
  localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_CYC   = DIV;
`else
  localparam int PAR_CYC   = 0;
`endif
  localparam int FRAME_CYC = (10 + STOP_BITS - 1) * DIV + PAR_CYC;
  localparam int N_SLOTS   = FRAME_CYC / DIV;
  localparam int STOP_SLOT = 9 + PAR_CYC / DIV;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       RsTx;
  logic       busy;
  logic [4:0] fifo_level;
  tx_state_t  state_dbg;
  int         cyc = 0;

  uart_tx_if tx_bus ();

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH),
    .STOP_BITS  (STOP_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_in      (tx_bus),
    .RsTx       (RsTx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  bit         mon_en  = 1'b0;
  bit         gap_chk = 1'b0;
  int         prev_start = -1;
  int         frames_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line monitor: samples each bit mid-cell after a falling start edge.
  initial begin : line_monitor
    forever begin
      @(negedge clk);
      if (mon_en && rst && RsTx == 1'b0) begin : one_frame
        int                 start_cyc;
        logic [N_SLOTS-1:0] slots;
        logic [7:0]         exp_b;
        bit                 aborted;
        start_cyc = cyc;
        slots     = '0;
        aborted   = 1'b0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (!mon_en || !rst) begin
            aborted = 1'b1;
            break;
          end
          if (k % DIV == DIV / 2) slots[k / DIV] = RsTx;
        end
        if (!aborted) begin
          check("start_bit", 32'(slots[0]), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
          end else begin
            exp_b = exp_q.pop_front();
            check("rx_byte", 32'(slots[8:1]), 32'(exp_b));
`ifdef UART_TX_PARITY_EN
            check("parity_bit", 32'(slots[9]), 32'(^exp_b));
`endif
          end
          for (int s = STOP_SLOT; s < N_SLOTS; s++) check("stop_bit", 32'(slots[s]), 32'd1);
          if (gap_chk && prev_start >= 0) check("frame_gap", 32'(start_cyc - prev_start), 32'(FRAME_CYC));
          prev_start = start_cyc;
          frames_seen++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    tx_bus.data_in  = b;
    tx_bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    tx_bus.valid_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Watchdog so the run always ends with a summary.
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- directed tests ----------------
  logic [7:0] burst [17] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h3C, 8'hC3,
                             8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F};
  int a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin : stimulus
    int e0;
    rst             = 1'b0;
    tx_bus.data_in  = '0;
    tx_bus.valid_in = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rstx",  32'(RsTx), 32'd1);
    check("rst_ready", 32'(tx_bus.ready_out), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(TX_IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Single byte 0xA5: exact latency and bit timing
    exp_q.push_back(8'hA5);
    push_byte(8'hA5);
    @(negedge clk);
    check("a5_t0_rstx",  32'(RsTx), 32'd1);
    check("a5_t0_level", 32'(fifo_level), 32'd1);
    check("a5_t0_busy",  32'(busy), 32'd1);
    for (int k = 1; k <= FRAME_CYC + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("a5_start_first", 32'(RsTx), 32'd0);
        check("a5_level_pop",   32'(fifo_level), 32'd0);
        check("a5_state_start", 32'(state_dbg), 32'(TX_START));
      end
      if (k == 10) check("a5_start_last", 32'(RsTx), 32'd0);
      if (k == 11) check("a5_bit0_first", 32'(RsTx), 32'd1);
      if (k >= 15 && k <= 85 && (k - 15) % 10 == 0)
        check($sformatf("a5_bit%0d", (k - 15) / 10), 32'(RsTx), 32'(a5_bits[(k - 15) / 10]));
      if (k == FRAME_CYC) begin
        check("a5_stop_last", 32'(RsTx), 32'd1);
        check("a5_busy_last", 32'(busy), 32'd1);
      end
      if (k == FRAME_CYC + 1) begin
        check("a5_busy_fall", 32'(busy), 32'd0);
        check("a5_state_idle", 32'(state_dbg), 32'(TX_IDLE));
      end
    end
    wait_idle(50, "a5_idle");

    // Burst of 17: 1 in flight + 16 queued, contiguous frames
    gap_chk    = 1'b1;
    prev_start = -1;
    e0         = 0;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(burst[i]);
      tx_bus.data_in  = burst[i];
      tx_bus.valid_in = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) e0 = cyc;
      if (i == 1) check("burst_push_pop_level", 32'(fifo_level), 32'd1);
    end
    check("burst_full_level", 32'(fifo_level), 32'd16);
    check("burst_full_ready", 32'(tx_bus.ready_out), 32'd0);
    tx_bus.data_in = 8'hEE;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("burst_ignore_push", 32'(fifo_level), 32'd16);
    tx_bus.valid_in = 1'b0;
    while (cyc < e0 + FRAME_CYC) @(negedge clk);
    check("burst_ready_held", 32'(tx_bus.ready_out), 32'd0);
    @(negedge clk);
    check("burst_ready_rise", 32'(tx_bus.ready_out), 32'd1);
    check("burst_level_15",   32'(fifo_level), 32'd15);
    wait_idle(17 * FRAME_CYC + 50, "burst_idle");
    check("burst_all_seen", 32'(exp_q.size()), 32'd0);
    gap_chk = 1'b0;

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0
    exp_q.push_back(8'h07);
    push_byte(8'h07);
    wait_idle(FRAME_CYC + 20, "par07_idle");
    exp_q.push_back(8'h03);
    push_byte(8'h03);
    wait_idle(FRAME_CYC + 20, "par03_idle");
`endif

    // Reset during data bit 3 with 4 bytes queued
    mon_en = 1'b0;
    e0     = 0;
    for (int i = 0; i < 5; i++) begin
      tx_bus.data_in  = (i == 0) ? 8'h00 : 8'h5A;
      tx_bus.valid_in = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) e0 = cyc;
    end
    tx_bus.valid_in = 1'b0;
    while (cyc < e0 + 45) @(negedge clk);
    check("mid_level_4", 32'(fifo_level), 32'd4);
    check("mid_bit3_low", 32'(RsTx), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_rstx",  32'(RsTx), 32'd1);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_ready", 32'(tx_bus.ready_out), 32'd1);
    check("mid_rst_busy",  32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(RsTx), 32'd1);
    mon_en = 1'b1;
    frames_seen = 0;
    exp_q.push_back(8'h3C);
    push_byte(8'h3C);
    wait_idle(FRAME_CYC + 20, "post_rst_3c_idle");
    check("post_rst_frames", 32'(frames_seen), 32'd1);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
